// File: rtl/encoder_ui_pkg.sv
// Shared encoder-UI constants, FSM encoding and the bounded step helper.
// PARAM_WRAP_EN: when defined, EDIT-mode steps wrap at the bounds instead of saturating.
package encoder_ui_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'b00;
    localparam logic [1:0] ENC_CW    = 2'b01;
    localparam logic [1:0] ENC_CCW   = 2'b10;
    localparam logic [1:0] ENC_PRESS = 2'b11;

    localparam logic [1:0] SEL_VOL    = 2'd0;
    localparam logic [1:0] SEL_OCT    = 2'd1;
    localparam logic [1:0] SEL_TIMBRE = 2'd2;

    typedef enum logic {
        SELECT = 1'b0,
        EDIT   = 1'b1
    } ui_state_e;

    // Values are zero-extended to 5 bits; the step itself is done one bit wider so
    // overflow past max and borrow below 0 are both visible before bounding.
    function automatic logic [4:0] param_step(input logic [4:0] cur, input logic [4:0] max,
                                              input logic up);
        logic [5:0] ext;
        logic [4:0] res;
        if (up) begin
            ext = {1'b0, cur} + 6'd1;
`ifdef PARAM_WRAP_EN
            res = (ext > {1'b0, max}) ? 5'd0 : ext[4:0];
`else
            res = (ext > {1'b0, max}) ? max : ext[4:0];
`endif
        end else begin
            ext = {1'b0, cur} - 6'd1;
`ifdef PARAM_WRAP_EN
            res = ext[5] ? max : ext[4:0];
`else
            res = ext[5] ? 5'd0 : ext[4:0];
`endif
        end
        return res;
    endfunction

endpackage

// File: rtl/encoder_param_ctrl_if.sv
// Encoder code in, user parameters and UI state out.
interface encoder_param_ctrl_if;
    logic [1:0] enc_code;
    logic [3:0] volume;
    logic [2:0] octave;
    logic [1:0] timbre;
    logic [1:0] sel;
    logic       edit_mode;
    logic       param_upd;

    modport master (output enc_code, input volume, octave, timbre, sel, edit_mode, param_upd);
    modport slave  (input enc_code, output volume, octave, timbre, sel, edit_mode, param_upd);
endinterface

// File: rtl/encoder_param_ctrl_event_sync.sv
// Synchronises the level-held encoder code, filters skew and emits one-cycle event pulses.
module enc_event_sync
    import encoder_ui_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] code,
    output logic       ev_cw,
    output logic       ev_ccw,
    output logic       ev_press
);
    logic [1:0] s1, s2, s3;
    logic [1:0] acc_code, last;
    logic       acc_vld, primed;
    logic [2:0] vld_pipe;

    // vld_pipe marks which of s1..s3 hold real samples since reset. The first stable
    // code after reset only seeds 'last', so a code held across reset makes no event.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 2'b00;
            s2       <= 2'b00;
            s3       <= 2'b00;
            vld_pipe <= 3'b000;
            acc_vld  <= 1'b0;
            acc_code <= 2'b00;
            last     <= 2'b00;
            primed   <= 1'b0;
            ev_cw    <= 1'b0;
            ev_ccw   <= 1'b0;
            ev_press <= 1'b0;
        end else begin
            s1       <= code;
            s2       <= s1;
            s3       <= s2;
            vld_pipe <= {vld_pipe[1:0], 1'b1};
            acc_vld  <= vld_pipe[2] && (s2 == s3);
            acc_code <= s2;
            ev_cw    <= 1'b0;
            ev_ccw   <= 1'b0;
            ev_press <= 1'b0;
            if (acc_vld) begin
                if (!primed) begin
                    primed <= 1'b1;
                    last   <= acc_code;
                end else if (acc_code != last) begin
                    last     <= acc_code;
                    ev_cw    <= (acc_code == ENC_CW);
                    ev_ccw   <= (acc_code == ENC_CCW);
                    ev_press <= (acc_code == ENC_PRESS);
                end
            end
        end
    end
endmodule

// File: rtl/encoder_param_ctrl.sv
// Two-mode encoder UI: SELECT navigates sel, EDIT steps volume/octave/timbre, with idle timeout.
// PARAM_WRAP_EN (see encoder_ui_pkg::param_step) makes EDIT steps wrap instead of saturate.
module encoder_param_ctrl
    import encoder_ui_pkg::*;
#(
    parameter int VOL_MAX     = 15,
    parameter int VOL_RESET   = 8,
    parameter int OCT_MAX     = 6,
    parameter int OCT_RESET   = 3,
    parameter int TIMBRE_MAX  = 3,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    encoder_param_ctrl_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic       ev_cw, ev_ccw, ev_press, any_ev, step_ev;
    ui_state_e  state, state_n;
    logic [1:0] sel_q, sel_n;
    logic [3:0] vol_q, vol_n;
    logic [2:0] oct_q, oct_n;
    logic [1:0] tim_q, tim_n;
    logic       upd_q, upd_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [4:0] vol_step, oct_step, tim_step;

    enc_event_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .code     (bus.enc_code),
        .ev_cw    (ev_cw),
        .ev_ccw   (ev_ccw),
        .ev_press (ev_press)
    );

    assign any_ev  = ev_cw | ev_ccw | ev_press;
    assign step_ev = ev_cw | ev_ccw;

    assign vol_step = param_step({1'b0, vol_q}, 5'(VOL_MAX), ev_cw);
    assign oct_step = param_step({2'b0, oct_q}, 5'(OCT_MAX), ev_cw);
    assign tim_step = param_step({3'b0, tim_q}, 5'(TIMBRE_MAX), ev_cw);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SELECT;
            sel_q <= SEL_VOL;
            vol_q <= 4'(VOL_RESET);
            oct_q <= 3'(OCT_RESET);
            tim_q <= 2'd0;
            upd_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            sel_q <= sel_n;
            vol_q <= vol_n;
            oct_q <= oct_n;
            tim_q <= tim_n;
            upd_q <= upd_n;
            cnt_q <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        vol_n   = vol_q;
        oct_n   = oct_q;
        tim_n   = tim_q;
        upd_n   = 1'b0;
        cnt_n   = cnt_q;
        case (state)
            SELECT: begin
                cnt_n = '0;
                if (ev_cw)
                    sel_n = (sel_q == SEL_TIMBRE) ? SEL_VOL : sel_q + 2'd1;
                else if (ev_ccw)
                    sel_n = (sel_q == SEL_VOL) ? SEL_TIMBRE : sel_q - 2'd1;
                else if (ev_press)
                    state_n = EDIT;
            end
            EDIT: begin
                if (any_ev) begin
                    // An event always beats a coinciding timeout.
                    cnt_n = '0;
                    if (ev_press) begin
                        state_n = SELECT;
                    end else if (step_ev) begin
                        case (sel_q)
                            SEL_VOL: if (vol_step != {1'b0, vol_q}) begin
                                vol_n = vol_step[3:0];
                                upd_n = 1'b1;
                            end
                            SEL_OCT: if (oct_step != {2'b0, oct_q}) begin
                                oct_n = oct_step[2:0];
                                upd_n = 1'b1;
                            end
                            SEL_TIMBRE: if (tim_step != {3'b0, tim_q}) begin
                                tim_n = tim_step[1:0];
                                upd_n = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_n = SELECT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_n = SELECT;
        endcase
    end

    assign bus.volume    = vol_q;
    assign bus.octave    = oct_q;
    assign bus.timbre    = tim_q;
    assign bus.sel       = sel_q;
    assign bus.edit_mode = (state == EDIT);
    assign bus.param_upd = upd_q;
endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Scenario bench for encoder_param_ctrl; a negedge monitor scores every param_upd pulse.
module tb_encoder_param_ctrl;
    import encoder_ui_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   upd_cnt = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int         due;
        logic [3:0] vol;
        logic [2:0] oct;
        logic [1:0] tim;
    } exp_t;

    exp_t sb[$];
    logic [3:0] m_vol = 4'd8;
    logic [2:0] m_oct = 3'd3;
    logic [1:0] m_tim = 2'd0;

    encoder_param_ctrl_if bus();

    encoder_param_ctrl #(.TIMEOUT_CYC(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A pin change driven at negedge cycle c is due on param_upd at cycle c+6.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() != 0 && cyc > sb[0].due) begin
                checks++;
                failures++;
                $display("FAIL upd_missing due=%0d now=%0d", sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (bus.param_upd === 1'b1) begin
                exp_t e;
                upd_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL upd_unexpected cyc=%0d vol=%0d oct=%0d tim=%0d",
                             cyc, bus.volume, bus.octave, bus.timbre);
                end else begin
                    e = sb.pop_front();
                    if (cyc !== e.due || bus.volume !== e.vol || bus.octave !== e.oct ||
                        bus.timbre !== e.tim) begin
                        failures++;
                        $display("FAIL upd_value got cyc=%0d v=%0d o=%0d t=%0d want cyc=%0d v=%0d o=%0d t=%0d",
                                 cyc, bus.volume, bus.octave, bus.timbre, e.due, e.vol, e.oct, e.tim);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [1:0] code, input int hold, input bit exp_upd);
        bus.enc_code = code;
        if (exp_upd) sb.push_back('{cyc + 6, m_vol, m_oct, m_tim});
        repeat (hold) @(negedge clk);
    endtask

    task automatic wait_edit(input logic lvl, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.edit_mode === lvl) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus.volume !== 4'd8 || bus.octave !== 3'd3 || bus.timbre !== 2'd0 ||
            bus.sel !== 2'd0 || bus.edit_mode !== 1'b0 || bus.param_upd !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%0d o=%0d t=%0d s=%0d e=%0d u=%0d want 8 3 0 0 0 0",
                     bus.volume, bus.octave, bus.timbre, bus.sel, bus.edit_mode, bus.param_upd);
        end
        repeat (8) @(negedge clk);
        mon_en = 1'b1;
        checks++;
        if (bus.sel !== 2'd0 || bus.edit_mode !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got sel=%0d edit=%0d want 0 0", bus.sel, bus.edit_mode);
        end
    endtask

    task automatic test_select_edit;
        int pulses;
        drive(ENC_CW, 10, 0);
        drive(ENC_IDLE, 10, 0);
        drive(ENC_PRESS, 10, 0);
        checks++;
        if (bus.sel !== 2'd1 || bus.edit_mode !== 1'b1) begin
            failures++;
            $display("FAIL enter_edit got sel=%0d edit=%0d want 1 1", bus.sel, bus.edit_mode);
        end
        pulses = upd_cnt;
        m_oct = 3'd4; drive(ENC_CW, 10, 1);
        m_oct = 3'd3; drive(ENC_CCW, 10, 1);
        m_oct = 3'd4; drive(ENC_CW, 10, 1);
        checks++;
        if (bus.octave !== 3'd4 || upd_cnt - pulses !== 3) begin
            failures++;
            $display("FAIL octave_steps got oct=%0d pulses=%0d want 4 3", bus.octave, upd_cnt - pulses);
        end
    endtask

    task automatic test_saturate;
        drive(ENC_PRESS, 8, 0);
        drive(ENC_CCW, 8, 0);
        drive(ENC_PRESS, 8, 0);
        checks++;
        if (bus.sel !== 2'd0 || bus.edit_mode !== 1'b1) begin
            failures++;
            $display("FAIL edit_volume got sel=%0d edit=%0d want 0 1", bus.sel, bus.edit_mode);
        end
        for (int i = 0; i < 7; i++) begin
            m_vol = m_vol + 4'd1;
            drive(ENC_CW, 8, 1);
            drive(ENC_IDLE, 8, 0);
        end
`ifdef PARAM_WRAP_EN
        m_vol = 4'd0;
        drive(ENC_CW, 8, 1);
`else
        drive(ENC_CW, 8, 0);
`endif
        checks++;
        if (bus.volume !== m_vol) begin
            failures++;
            $display("FAIL volume_top got %0d want %0d", bus.volume, m_vol);
        end
        drive(ENC_PRESS, 8, 0);
        checks++;
        if (bus.edit_mode !== 1'b0) begin
            failures++;
            $display("FAIL exit_edit got edit=%0d want 0", bus.edit_mode);
        end
    endtask

    task automatic test_select_nav;
        drive(ENC_CCW, 8, 0);
        checks++;
        if (bus.sel !== 2'd2) begin
            failures++;
            $display("FAIL sel_wrap_down got %0d want 2", bus.sel);
        end
        drive(ENC_CW, 8, 0);
        checks++;
        if (bus.sel !== 2'd0 || bus.volume !== m_vol || bus.octave !== m_oct || bus.timbre !== m_tim) begin
            failures++;
            $display("FAIL sel_wrap_up got s=%0d v=%0d o=%0d t=%0d want 0 %0d %0d %0d",
                     bus.sel, bus.volume, bus.octave, bus.timbre, m_vol, m_oct, m_tim);
        end
    endtask

    task automatic test_glitch;
        bus.enc_code = ENC_PRESS;
        @(negedge clk);
        bus.enc_code = ENC_CW;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.edit_mode !== 1'b0 || bus.sel !== 2'd0) begin
            failures++;
            $display("FAIL glitch_press got edit=%0d sel=%0d want 0 0", bus.edit_mode, bus.sel);
        end
    endtask

    task automatic test_timeout;
        int r, f;
        drive(ENC_CCW, 8, 0);
        drive(ENC_PRESS, 0, 0);
        wait_edit(1'b1, 20, r);
        wait_edit(1'b0, 40, f);
        checks++;
        if (r < 0 || f < 0 || f - r !== 20) begin
            failures++;
            $display("FAIL timeout_len got rise=%0d fall=%0d want fall-rise=20", r, f);
        end
        // Second pass: a CW event lands exactly on the last idle cycle and restarts the count.
        drive(ENC_IDLE, 8, 0);
        drive(ENC_PRESS, 0, 0);
        wait_edit(1'b1, 20, r);
        repeat (14) @(negedge clk);
        m_tim = 2'd1;
        drive(ENC_CW, 0, 1);
        wait_edit(1'b0, 60, f);
        checks++;
        if (r < 0 || f < 0 || f - r !== 40) begin
            failures++;
            $display("FAIL timeout_restart got rise=%0d fall=%0d want fall-rise=40", r, f);
        end
        drive(ENC_PRESS, 8, 0);
        m_tim = 2'd0;
        drive(ENC_CCW, 8, 1);
        drive(ENC_IDLE, 8, 0);
`ifdef PARAM_WRAP_EN
        m_tim = 2'd3;
        drive(ENC_CCW, 8, 1);
`else
        drive(ENC_CCW, 8, 0);
`endif
        checks++;
        if (bus.timbre !== m_tim) begin
            failures++;
            $display("FAIL timbre_floor got %0d want %0d", bus.timbre, m_tim);
        end
        drive(ENC_PRESS, 8, 0);
    endtask

    task automatic test_reset_mid;
        drive(ENC_CCW, 8, 0);
        drive(ENC_PRESS, 8, 0);
        m_oct = 3'd5;
        drive(ENC_CW, 8, 1);
        checks++;
        if (bus.octave !== 3'd5 || bus.edit_mode !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got oct=%0d edit=%0d want 5 1", bus.octave, bus.edit_mode);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_vol = 4'd8; m_oct = 3'd3; m_tim = 2'd0;
        checks++;
        if (bus.octave !== 3'd3 || bus.volume !== 4'd8 || bus.timbre !== 2'd0 ||
            bus.sel !== 2'd0 || bus.edit_mode !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got o=%0d v=%0d t=%0d s=%0d e=%0d want 3 8 0 0 0",
                     bus.octave, bus.volume, bus.timbre, bus.sel, bus.edit_mode);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (bus.sel !== 2'd0 || bus.edit_mode !== 1'b0) begin
            failures++;
            $display("FAIL held_code got sel=%0d edit=%0d want 0 0", bus.sel, bus.edit_mode);
        end
    endtask

    initial begin
        bus.enc_code = ENC_IDLE;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_select_edit;
        test_saturate;
        test_select_nav;
        test_glitch;
        test_timeout;
        test_reset_mid;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
